// File: rtl/tristate_bus_pkg.sv
// ---------------------------------------------------------------------------
// tristate_bus_pkg
//   Shared types and sizing helpers for the tristate bus controller family.
//   - bus_state_t : controller state (IDLE / DRIVE / TURN)
//   - owner_w()   : width of an owner index for n requesters
//   - cnt_w()     : width of a counter that must hold 0..max_val
// ---------------------------------------------------------------------------
package tristate_bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        TURN  = 2'd2
    } bus_state_t;

    // Index width for n requesters; never narrower than one bit.
    function automatic int owner_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Width of a counter whose largest value is max_val.
    function automatic int cnt_w(input int max_val);
        return (max_val <= 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/tristate_bus_ctrl_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Purely combinational round-robin picker. The search starts at
//   last_owner+1 and wraps, so the previous owner is always lowest priority.
// Ports:
//   req        in   N        request vector
//   last_owner in   owner_w  index of the previous winner
//   winner     out  owner_w  index of the first requester after last_owner
//   any_req    out  1        at least one request is asserted
// ---------------------------------------------------------------------------
module rr_arbiter
    import tristate_bus_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]          req,
    input  logic [owner_w(N)-1:0] last_owner,
    output logic [owner_w(N)-1:0] winner,
    output logic                  any_req
);

    localparam int W = owner_w(N);

    logic [W-1:0] hi_win;
    logic [W-1:0] lo_win;
    logic         hi_found;

    // Two passes folded into one loop: the lowest requester above last_owner
    // wins; failing that, the lowest requester overall (the wrap-around).
    // Walking downwards lets the last assignment be the lowest index.
    // NOTE: every variable written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        hi_win   = '0;
        lo_win   = '0;
        hi_found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_win = W'(i);
                if (W'(i) > last_owner) begin
                    hi_win   = W'(i);
                    hi_found = 1'b1;
                end
            end
        end
        winner = hi_found ? hi_win : lo_win;
    end

    assign any_req = |req;

endmodule

// File: rtl/tristate_bus_ctrl.sv
// ---------------------------------------------------------------------------
// tristate_bus_ctrl
//   Multi-master tristate bus driver: round-robin arbitration, bounded tenure
//   (MAX_HOLD cycles) and TURN_CYCLES all-drivers-off cycles between owners.
//   The drive enable comes straight from the registered state, so two owners
//   can never overlap on the bus.
//   Optional build macro TRISTATE_BUS_KEEPER_EN adds a keeper register so
//   bus_in never shows Z/X while the bus is released.
// Ports:
//   clk     in     1                sole clock, rising edge
//   rst     in     1                synchronous active-high reset
//   req     in     N_MASTERS        level-sensitive bus requests
//   din     in     N_MASTERS*WIDTH  write data, master i at [i*WIDTH +: WIDTH]
//   gnt     out    N_MASTERS        one-hot grant, zero unless driving
//   owner   out    owner_w          current / last owner index
//   busy    out    1                high in DRIVE or TURN
//   bus     inout  WIDTH            shared tristate bus
//   bus_in  out    WIDTH            bus value as seen by readers
// ---------------------------------------------------------------------------
module tristate_bus_ctrl
    import tristate_bus_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int N_MASTERS   = 4,
    parameter int MAX_HOLD    = 16,
    parameter int TURN_CYCLES = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_MASTERS-1:0]          req,
    input  logic [N_MASTERS*WIDTH-1:0]    din,
    output logic [N_MASTERS-1:0]          gnt,
    output logic [owner_w(N_MASTERS)-1:0] owner,
    output logic                          busy,
    inout  wire  [WIDTH-1:0]              bus,
    output logic [WIDTH-1:0]              bus_in
);

    localparam int OWNER_W = owner_w(N_MASTERS);
    localparam int HOLD_W  = cnt_w(MAX_HOLD - 1);
    localparam int TURN_W  = cnt_w(TURN_CYCLES - 1);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [TURN_W-1:0] TURN_LAST = TURN_W'(TURN_CYCLES - 1);

    bus_state_t           state, state_n;
    logic [N_MASTERS-1:0] gnt_n;
    logic [OWNER_W-1:0]   owner_n;
    logic [HOLD_W-1:0]    hold_cnt, hold_n;
    logic [TURN_W-1:0]    turn_cnt, turn_n;

    logic [OWNER_W-1:0]   winner;
    logic                 any_req;
    logic                 grant_now;
    logic [WIDTH-1:0]     drive_data;

    rr_arbiter #(
        .N (N_MASTERS)
    ) u_arb (
        .req        (req),
        .last_owner (owner),
        .winner     (winner),
        .any_req    (any_req)
    );

    // Next-state logic. A grant can start from IDLE or from the last TURN
    // cycle; both share the grant block at the bottom.
    always_comb begin
        state_n   = state;
        gnt_n     = gnt;
        owner_n   = owner;
        hold_n    = hold_cnt;
        turn_n    = turn_cnt;
        grant_now = 1'b0;

        unique case (state)
            IDLE: begin
                grant_now = any_req;
            end
            DRIVE: begin
                hold_n = hold_cnt + HOLD_W'(1);
                // Either release condition leads to the same single TURN.
                if (!req[owner] || hold_cnt == HOLD_LAST) begin
                    state_n = TURN;
                    gnt_n   = '0;
                    turn_n  = '0;
                end
            end
            TURN: begin
                turn_n = turn_cnt + TURN_W'(1);
                if (turn_cnt == TURN_LAST) begin
                    if (any_req) grant_now = 1'b1;
                    else         state_n   = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                gnt_n   = '0;
            end
        endcase

        if (grant_now) begin
            state_n        = DRIVE;
            gnt_n          = '0;
            gnt_n[winner]  = 1'b1;
            owner_n        = winner;
            hold_n         = '0;
        end
    end

    // Owner resets to the last index so master 0 is searched first.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= '0;
            owner    <= OWNER_W'(N_MASTERS - 1);
            hold_cnt <= '0;
            turn_cnt <= '0;
        end else begin
            state    <= state_n;
            gnt      <= gnt_n;
            owner    <= owner_n;
            hold_cnt <= hold_n;
            turn_cnt <= turn_n;
        end
    end

    assign busy = (state != IDLE);

    // Select the owner's slice; data is combinational, only the enable is
    // registered.
    always_comb begin
        drive_data = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (owner == OWNER_W'(i)) drive_data = din[i*WIDTH +: WIDTH];
        end
    end

    assign bus = (state == DRIVE) ? drive_data : {WIDTH{1'bz}};

`ifdef TRISTATE_BUS_KEEPER_EN
    logic [WIDTH-1:0] keeper;

    // Holds the last driven value so readers see a defined level while the
    // bus floats.
    always_ff @(posedge clk) begin
        if (rst)                 keeper <= '0;
        else if (state == DRIVE) keeper <= bus;
    end

    assign bus_in = (state == DRIVE) ? bus : keeper;
`else
    assign bus_in = bus;
`endif

endmodule

// File: tb/tb_tristate_bus_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tristate_bus_ctrl
//   Three controller instances share clk/rst/din:
//     a: MAX_HOLD=16, TURN_CYCLES=1  (reset, single master, hold limit,
//                                     mid-tenure reset)
//     b: MAX_HOLD=2,  TURN_CYCLES=1  (round-robin contention)
//     c: MAX_HOLD=3,  TURN_CYCLES=3  (simultaneous exit, long turnaround)
//   Each scenario pushes per-cycle expectations to a queue and pops one per
//   clock, comparing #1 after the rising edge.
// ---------------------------------------------------------------------------
module tb_tristate_bus_ctrl;

`ifdef TRISTATE_BUS_KEEPER_EN
    localparam bit KEEPER = 1'b1;
`else
    localparam bit KEEPER = 1'b0;
`endif

    typedef struct packed {
        logic       rst;
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] owner;
        logic       busy;
        logic       drv;   // bus must carry data; otherwise must not
        logic [7:0] data;
    } item_t;

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] owner;
        logic       busy;
        logic [7:0] bus;
        logic [7:0] bus_in;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_a = '0, req_b = '0, req_c = '0;
    logic [31:0] din;

    logic [3:0]  gnt_a, gnt_b, gnt_c;
    logic [1:0]  owner_a, owner_b, owner_c;
    logic        busy_a, busy_b, busy_c;
    wire  [7:0]  bus_a, bus_b, bus_c;
    logic [7:0]  bus_in_a, bus_in_b, bus_in_c;

    logic [7:0]  dtab [4];
    logic [7:0]  keep_exp [3];
    item_t       sb [$];
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    tristate_bus_ctrl #(.WIDTH(8), .N_MASTERS(4), .MAX_HOLD(16), .TURN_CYCLES(1)) dut_a (
        .clk(clk), .rst(rst), .req(req_a), .din(din), .gnt(gnt_a), .owner(owner_a),
        .busy(busy_a), .bus(bus_a), .bus_in(bus_in_a));

    tristate_bus_ctrl #(.WIDTH(8), .N_MASTERS(4), .MAX_HOLD(2), .TURN_CYCLES(1)) dut_b (
        .clk(clk), .rst(rst), .req(req_b), .din(din), .gnt(gnt_b), .owner(owner_b),
        .busy(busy_b), .bus(bus_b), .bus_in(bus_in_b));

    tristate_bus_ctrl #(.WIDTH(8), .N_MASTERS(4), .MAX_HOLD(3), .TURN_CYCLES(3)) dut_c (
        .clk(clk), .rst(rst), .req(req_c), .din(din), .gnt(gnt_c), .owner(owner_c),
        .busy(busy_c), .bus(bus_c), .bus_in(bus_in_c));

    function automatic logic [7:0] dval(input logic [1:0] m);
        return dtab[m];
    endfunction

    function automatic obs_t observe(input int k);
        obs_t o;
        case (k)
            1:       o = '{gnt_b, owner_b, busy_b, bus_b, bus_in_b};
            2:       o = '{gnt_c, owner_c, busy_c, bus_c, bus_in_c};
            default: o = '{gnt_a, owner_a, busy_a, bus_a, bus_in_a};
        endcase
        return o;
    endfunction

    task automatic push(input logic r, input logic [3:0] q, input logic [3:0] g,
                        input logic [1:0] o, input logic b, input logic d, input logic [7:0] v);
        sb.push_back('{r, q, g, o, b, d, v});
    endtask

    // DRIVE by master m / TURN after master m / IDLE with owner m.
    task automatic push_d(input logic [3:0] q, input logic [1:0] m);
        push(1'b0, q, 4'b0001 << m, m, 1'b1, 1'b1, dval(m));
    endtask

    task automatic push_t(input logic [3:0] q, input logic [1:0] m);
        push(1'b0, q, 4'b0000, m, 1'b1, 1'b0, dval(m));
    endtask

    task automatic push_i(input logic [3:0] q, input logic [1:0] m);
        push(1'b0, q, 4'b0000, m, 1'b0, 1'b0, dval(m));
    endtask

    // Apply one item's inputs, advance one clock, sample. The one-hot grant
    // invariant is checked on every instance every step.
    task automatic step(input int k, input item_t it, output obs_t o);
        rst = it.rst;
        case (k)
            1:       req_b = it.req;
            2:       req_c = it.req;
            default: req_a = it.req;
        endcase
        @(posedge clk);
        #1;
        if (it.rst) foreach (keep_exp[j]) keep_exp[j] = 8'h00;
        o = observe(k);
        total++;
        if ($countones(gnt_a) > 1 || $countones(gnt_b) > 1 || $countones(gnt_c) > 1) begin
            bad++;
            $display("FAIL gnt_onehot: gnt_a=%b gnt_b=%b gnt_c=%b, want at most one bit each",
                     gnt_a, gnt_b, gnt_c);
        end
    endtask

    task automatic test_reset();
        obs_t o;
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 3; k++) begin
                o = observe(k);
                total++;
                if (o.gnt !== 4'b0000 || o.owner !== 2'd3 || o.busy !== 1'b0 ||
                    o.bus === dval(2'd3) || (KEEPER && o.bus_in !== 8'h00)) begin
                    bad++;
                    $display("FAIL reset inst%0d cyc%0d: gnt=%b owner=%0d busy=%b bus=%h bus_in=%h, want gnt=0000 owner=3 busy=0 bus released",
                             k, c, o.gnt, o.owner, o.busy, o.bus, o.bus_in);
                end
            end
        end
        rst = 1'b0;
        foreach (keep_exp[j]) keep_exp[j] = 8'h00;
    endtask

    task automatic test_single_master();
        item_t it;
        obs_t  o;
        int    cyc = 0;
        for (int c = 0; c < 3; c++) push_d(4'b0100, 2'd2);
        push_t(4'b0000, 2'd2);
        push_i(4'b0000, 2'd2);
        while (sb.size() != 0) begin
            it = sb.pop_front();
            step(0, it, o);
            if ({o.gnt, o.owner, o.busy} !== {it.gnt, it.owner, it.busy} ||
                (it.drv ? (o.bus !== it.data) : (o.bus === it.data)) ||
                ((KEEPER || it.drv) && o.bus_in !== (it.drv ? it.data : keep_exp[0]))) begin
                bad++;
                $display("FAIL single cyc%0d: gnt=%b owner=%0d busy=%b bus=%h bus_in=%h, want gnt=%b owner=%0d busy=%b drive=%b data=%h",
                         cyc, o.gnt, o.owner, o.busy, o.bus, o.bus_in, it.gnt, it.owner, it.busy, it.drv, it.data);
            end
            if (it.drv) keep_exp[0] = it.data;
            cyc++;
        end
    endtask

    task automatic test_round_robin();
        item_t      it;
        obs_t       o;
        int         cyc = 0;
        logic [1:0] order [5];
        order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        foreach (order[n]) begin
            push_d(4'b1111, order[n]);
            push_d(4'b1111, order[n]);
            push_t(4'b1111, order[n]);
        end
        push_i(4'b0000, 2'd0);
        while (sb.size() != 0) begin
            it = sb.pop_front();
            step(1, it, o);
            if ({o.gnt, o.owner, o.busy} !== {it.gnt, it.owner, it.busy} ||
                (it.drv ? (o.bus !== it.data) : (o.bus === it.data)) ||
                ((KEEPER || it.drv) && o.bus_in !== (it.drv ? it.data : keep_exp[1]))) begin
                bad++;
                $display("FAIL round_robin cyc%0d: gnt=%b owner=%0d busy=%b bus=%h bus_in=%h, want gnt=%b owner=%0d busy=%b drive=%b data=%h",
                         cyc, o.gnt, o.owner, o.busy, o.bus, o.bus_in, it.gnt, it.owner, it.busy, it.drv, it.data);
            end
            if (it.drv) keep_exp[1] = it.data;
            cyc++;
        end
    endtask

    task automatic test_hold_limit();
        item_t it;
        obs_t  o;
        int    cyc = 0;
        for (int c = 0; c < 40; c++) begin
            if ((c % 17) < 16) push_d(4'b0001, 2'd0);
            else               push_t(4'b0001, 2'd0);
        end
        push_t(4'b0000, 2'd0);
        push_i(4'b0000, 2'd0);
        while (sb.size() != 0) begin
            it = sb.pop_front();
            step(0, it, o);
            if ({o.gnt, o.owner, o.busy} !== {it.gnt, it.owner, it.busy} ||
                (it.drv ? (o.bus !== it.data) : (o.bus === it.data)) ||
                ((KEEPER || it.drv) && o.bus_in !== (it.drv ? it.data : keep_exp[0]))) begin
                bad++;
                $display("FAIL hold_limit cyc%0d: gnt=%b owner=%0d busy=%b bus=%h bus_in=%h, want gnt=%b owner=%0d busy=%b drive=%b data=%h",
                         cyc, o.gnt, o.owner, o.busy, o.bus, o.bus_in, it.gnt, it.owner, it.busy, it.drv, it.data);
            end
            if (it.drv) keep_exp[0] = it.data;
            cyc++;
        end
    endtask

    task automatic test_mid_reset();
        item_t it;
        obs_t  o;
        int    cyc = 0;
        push_d(4'b0010, 2'd1);
        push_d(4'b0010, 2'd1);
        // Reset edge: grant and drive drop at once, no TURN, owner back to 3.
        push(1'b1, 4'b0011, 4'b0000, 2'd3, 1'b0, 1'b0, dval(2'd1));
        push_d(4'b0011, 2'd0);
        push_t(4'b0010, 2'd0);
        push_i(4'b0000, 2'd0);
        while (sb.size() != 0) begin
            it = sb.pop_front();
            step(0, it, o);
            if ({o.gnt, o.owner, o.busy} !== {it.gnt, it.owner, it.busy} ||
                (it.drv ? (o.bus !== it.data) : (o.bus === it.data)) ||
                ((KEEPER || it.drv) && o.bus_in !== (it.drv ? it.data : keep_exp[0]))) begin
                bad++;
                $display("FAIL mid_reset cyc%0d: gnt=%b owner=%0d busy=%b bus=%h bus_in=%h, want gnt=%b owner=%0d busy=%b drive=%b data=%h",
                         cyc, o.gnt, o.owner, o.busy, o.bus, o.bus_in, it.gnt, it.owner, it.busy, it.drv, it.data);
            end
            if (it.drv) keep_exp[0] = it.data;
            cyc++;
        end
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        item_t it;
        obs_t  o;
        int    cyc = 0;
        // Request drops on the same edge the hold limit hits: one TURN of 3.
        for (int c = 0; c < 3; c++) push_d(4'b0100, 2'd2);
        for (int c = 0; c < 3; c++) push_t(4'b0000, 2'd2);
        // Request present at the last TURN edge: straight into DRIVE.
        push_d(4'b1001, 2'd3);
        for (int c = 0; c < 3; c++) push_t(4'b0000, 2'd3);
        push_i(4'b0000, 2'd3);
        while (sb.size() != 0) begin
            it = sb.pop_front();
            step(2, it, o);
            if ({o.gnt, o.owner, o.busy} !== {it.gnt, it.owner, it.busy} ||
                (it.drv ? (o.bus !== it.data) : (o.bus === it.data)) ||
                ((KEEPER || it.drv) && o.bus_in !== (it.drv ? it.data : keep_exp[2]))) begin
                bad++;
                $display("FAIL back_to_back cyc%0d: gnt=%b owner=%0d busy=%b bus=%h bus_in=%h, want gnt=%b owner=%0d busy=%b drive=%b data=%h",
                         cyc, o.gnt, o.owner, o.busy, o.bus, o.bus_in, it.gnt, it.owner, it.busy, it.drv, it.data);
            end
            if (it.drv) keep_exp[2] = it.data;
            cyc++;
        end
    endtask

    initial begin
        dtab = '{8'h11, 8'h5A, 8'hA5, 8'hC3};
        din  = {dtab[3], dtab[2], dtab[1], dtab[0]};
        foreach (keep_exp[j]) keep_exp[j] = 8'h00;

        test_reset();
        test_single_master();
        test_round_robin();
        test_hold_limit();
        test_mid_reset();
        test_back_to_back();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
